axi_ic_r_burst: RTL
===================

AXI_IC_R_BURST -- requirements
Module: axi_ic_r_burst

Interface
REQ-001 SHALL have parameter NumMasters, 2, number of upstream AXI masters receiving R beats (1..16).
REQ-002 SHALL have parameter NumSlaves, 2, number of downstream AXI slaves returning R beats (1..16).
REQ-003 SHALL have parameter AxiBusWidth, 128, rdata width in bits.
REQ-004 SHALL have parameter IdWidth, 8, rid width; master index is in rid[IdWidth-1 -: MstSelWidth], where MstSelWidth = max(1, clog2(NumMasters)).
REQ-005 SHALL have parameter FifoDepth, 4, per-master output FIFO depth in beats (power of 2, >=2).
REQ-006 SHALL use one clock and an asynchronous, active-low reset:
- aclk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have the following slave-side ports:
- s_rvalid  in  NumSlaves  per-slave rvalid.
- s_rready  out  NumSlaves  per-slave rready.
- s_rid  in  NumSlaves*IdWidth  packed rid, slave j at [j*IdWidth +: IdWidth].
- s_rdata  in  NumSlaves*AxiBusWidth  packed rdata.
- s_rresp  in  NumSlaves*2  packed rresp.
- s_rlast  in  NumSlaves  per-slave rlast.
REQ-008 SHALL have the following master-side ports:
- m_rvalid  out  NumMasters  per-master rvalid.
- m_rready  in  NumMasters  per-master rready.
- m_rid  out  NumMasters*IdWidth  packed rid.
- m_rdata  out  NumMasters*AxiBusWidth  packed rdata.
- m_rresp  out  NumMasters*2  packed rresp.
- m_rlast  out  NumMasters  per-master rlast.
- err_drop_o  out  NumSlaves  one-cycle pulse per slave whose beat was discarded.

Function
REQ-009 SHALL decode target master t(j) of slave j from the rid master-index field each cycle.
REQ-010 SHALL treat slave j as requesting master i when s_rvalid[j]=1 and t(j)=i.
REQ-011 SHALL run one round-robin arbiter per master, with states IDLE and LOCKED and a priority pointer ptr (0..NumSlaves-1).
REQ-012 In IDLE, the arbiter SHALL grant the first requesting slave found by searching upward from ptr with wrap-around; with no requester there SHALL be no grant.
REQ-013 In LOCKED, the arbiter SHALL grant only the locked slave, regardless of other requests.
REQ-014 A beat SHALL be accepted when s_rvalid[j] and s_rready[j] are both 1.
REQ-015 Lock transitions SHALL be:
- IDLE->LOCKED on an accepted beat with rlast=0, recording the slave.
- LOCKED->IDLE on an accepted beat with rlast=1.
- A single-beat burst (rlast=1 on the first beat) SHALL leave the arbiter in IDLE.
REQ-016 On every accepted rlast=1 beat, ptr SHALL become (granted slave + 1) mod NumSlaves.
REQ-017 s_rready[j] SHALL be 1 iff slave j is granted by master t(j) and FIFO t(j) is not full; s_rready SHALL NOT depend combinationally on m_rready.
REQ-018 Each master SHALL have a FIFO of FifoDepth entries of {rlast, rresp, rid, rdata}, and every accepted beat SHALL be pushed into it.
REQ-019 m_rvalid[i] SHALL equal FIFO i non-empty, with the m_r* data fields driven from the FIFO head; a pop SHALL occur when m_rvalid[i] and m_rready[i] are both 1.
REQ-020 Minimum latency SHALL be one cycle: a beat accepted at edge N SHALL be visible on the m_r* outputs after edge N.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged; a full FIFO SHALL accept no push even if a pop occurs in the same cycle.
REQ-022 Beats from one slave SHALL be delivered in acceptance order, and the fields of each beat SHALL be passed through unmodified.
REQ-023 If t(j) >= NumMasters, slave j SHALL be given s_rready[j]=1, the beat SHALL be discarded, and err_drop_o[j] SHALL pulse high in the following cycle.

Reset
REQ-024 While rst_n=0, the block SHALL hold:
- all FIFOs empty and m_rvalid=0.
- s_rready=0 and err_drop_o=0.
- all arbiters in IDLE with ptr=0.
REQ-025 Assertion of rst_n SHALL take effect asynchronously; deassertion SHALL be used synchronously to aclk. A partially delivered burst SHALL be dropped, with no recovery.

Verification
All scenarios use NumMasters=2, NumSlaves=2, AxiBusWidth=32, IdWidth=4, FifoDepth=4 unless stated.
REQ-026 Single beat: slave0 sends rid=4'h8, rdata=32'hA5A5A5A5, rresp=0, rlast=1 -> one cycle later m_rvalid[1]=1 with the same fields; m_rvalid[0] stays 0.
REQ-027 Burst lock: slave0 sends a 4-beat burst (rid=4'h1) and slave1 a 1-beat burst (rid=4'h2) to master0 in the same cycle -> master0 receives all 4 slave0 beats then the slave1 beat; s_rready[1]=0 until slave0's rlast is accepted.
REQ-028 Backpressure: m_rready[0]=0 while slave0 offers 6 beats -> 4 beats accepted, then s_rready[0]=0; releasing m_rready[0] -> all 6 beats delivered in order.
REQ-029 Fairness: both slaves continuously offer single beats to master0 -> grants alternate 0,1,0,1.
REQ-030 Drop: with NumMasters=3 and IdWidth=4, slave1 sends rid=4'hC -> s_rready[1]=1, no m_rvalid asserts, err_drop_o[1]=1 for exactly one cycle.
REQ-031 Reset mid-burst: rst_n driven low after 2 of 4 beats -> m_rvalid=0 and s_rready=0 immediately; after release, a new 1-beat burst from slave1 is granted and delivered.

Source files
------------

// File: rtl/axi_ic_r_burst_if.sv
// AXI read-data bundle between the R-channel interconnect and its environment.
// slave: the interconnect's view. master: the environment driving slave beats and sinking master beats.
interface axi_ic_r_burst_if #(
    parameter int NumMasters  = 2,
    parameter int NumSlaves   = 2,
    parameter int AxiBusWidth = 128,
    parameter int IdWidth     = 8
);
    // Handshakes are plain AXI: a beat moves on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a raised valid holds its payload until accepted.
    logic [NumSlaves-1:0]             s_rvalid;
    logic [NumSlaves-1:0]             s_rready;
    logic [NumSlaves*IdWidth-1:0]     s_rid;
    logic [NumSlaves*AxiBusWidth-1:0] s_rdata;
    logic [NumSlaves*2-1:0]           s_rresp;
    logic [NumSlaves-1:0]             s_rlast;

    logic [NumMasters-1:0]             m_rvalid;
    logic [NumMasters-1:0]             m_rready;
    logic [NumMasters*IdWidth-1:0]     m_rid;
    logic [NumMasters*AxiBusWidth-1:0] m_rdata;
    logic [NumMasters*2-1:0]           m_rresp;
    logic [NumMasters-1:0]             m_rlast;

    // Per-master arbiter state (1 = LOCKED on a burst)
    logic [NumMasters-1:0]             arb_locked;

    modport slave (
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, m_rready,
        output s_rready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, arb_locked
    );

    modport master (
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, m_rready,
        input  s_rready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, arb_locked
    );
endinterface

// File: rtl/axi_ic_r_burst.sv
// AXI R-channel return path: routes slave beats to masters by rid, with per-master
// burst-locking round-robin arbitration and a per-master output FIFO.
module axi_ic_r_burst #(
    parameter int NumMasters  = 2,
    parameter int NumSlaves   = 2,
    parameter int AxiBusWidth = 128,
    parameter int IdWidth     = 8,
    parameter int FifoDepth   = 4
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    axi_ic_r_burst_if.slave      bus,
    output logic [NumSlaves-1:0] err_drop_o
);
    localparam int MstSelWidth = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int SlvSelWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int PtrWidth    = $clog2(FifoDepth);
    localparam int BeatWidth   = 1 + 2 + IdWidth + AxiBusWidth;
    localparam logic [MstSelWidth:0] NumMastersW = NumMasters[MstSelWidth:0];
    localparam logic [PtrWidth:0]    PtrOne      = 1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef logic [SlvSelWidth-1:0] slv_idx_t;
    typedef logic [BeatWidth-1:0]   beat_t;

    arb_state_e           state_q [NumMasters];
    slv_idx_t             lock_q  [NumMasters];
    slv_idx_t             ptr_q   [NumMasters];
    logic [PtrWidth:0]    wr_q    [NumMasters];
    logic [PtrWidth:0]    rd_q    [NumMasters];
    beat_t                mem_q   [NumMasters][FifoDepth];
    logic                 run_q;
    logic [NumSlaves-1:0] err_drop_q;

    logic [MstSelWidth-1:0] tgt [NumSlaves];
    logic [NumSlaves-1:0]   bad_tgt;
    logic [NumSlaves-1:0]   req [NumMasters];
    logic [NumMasters-1:0]  gnt_vld;
    slv_idx_t               gnt_idx [NumMasters];
    logic [NumMasters-1:0]  full;
    logic [NumMasters-1:0]  push;
    logic [NumMasters-1:0]  pop;
    beat_t                  push_beat [NumMasters];
    beat_t                  head [NumMasters];

    function automatic slv_idx_t wrap_add(slv_idx_t base, int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NumSlaves) sum = sum - NumSlaves;
        return slv_idx_t'(sum);
    endfunction

    // Target master comes from the top rid bits; indices past NumMasters are sunk.
    always_comb begin
        for (int j = 0; j < NumSlaves; j++) begin
            tgt[j]     = bus.s_rid[j*IdWidth + IdWidth - 1 -: MstSelWidth];
            bad_tgt[j] = ({1'b0, tgt[j]} >= NumMastersW);
        end
        for (int i = 0; i < NumMasters; i++) begin
            for (int j = 0; j < NumSlaves; j++) begin
                req[i][j] = bus.s_rvalid[j] && !bad_tgt[j] && (tgt[j] == MstSelWidth'(i));
            end
        end
    end

    // Descending scan so the last hit written is the nearest requester above ptr.
    always_comb begin
        for (int i = 0; i < NumMasters; i++) begin
            gnt_vld[i] = 1'b0;
            gnt_idx[i] = '0;
            if (state_q[i] == ARB_LOCKED) begin
                gnt_idx[i] = lock_q[i];
                gnt_vld[i] = req[i][lock_q[i]];
            end else begin
                for (int k = NumSlaves - 1; k >= 0; k--) begin
                    if (req[i][wrap_add(ptr_q[i], k)]) begin
                        gnt_vld[i] = 1'b1;
                        gnt_idx[i] = wrap_add(ptr_q[i], k);
                    end
                end
            end
        end
    end

    // FIFO status and master-side outputs come straight from registers.
    always_comb begin
        bus.m_rvalid   = '0;
        bus.m_rid      = '0;
        bus.m_rdata    = '0;
        bus.m_rresp    = '0;
        bus.m_rlast    = '0;
        bus.arb_locked = '0;
        for (int i = 0; i < NumMasters; i++) begin
            full[i] = (wr_q[i][PtrWidth] != rd_q[i][PtrWidth]) &&
                      (wr_q[i][PtrWidth-1:0] == rd_q[i][PtrWidth-1:0]);
            head[i] = mem_q[i][rd_q[i][PtrWidth-1:0]];
            bus.m_rvalid[i] = (wr_q[i] != rd_q[i]);
            pop[i] = bus.m_rvalid[i] && bus.m_rready[i];
            bus.m_rlast[i] = head[i][BeatWidth-1];
            bus.m_rresp[i*2 +: 2] = head[i][BeatWidth-2 -: 2];
            bus.m_rid[i*IdWidth +: IdWidth] = head[i][AxiBusWidth +: IdWidth];
            bus.m_rdata[i*AxiBusWidth +: AxiBusWidth] = head[i][AxiBusWidth-1:0];
            bus.arb_locked[i] = (state_q[i] == ARB_LOCKED);
        end
    end

    // run_q keeps rready low until the first edge after reset release.
    always_comb begin
        bus.s_rready = bad_tgt & {NumSlaves{run_q}};
        for (int i = 0; i < NumMasters; i++) begin
            push[i] = run_q && gnt_vld[i] && !full[i];
            push_beat[i] = {bus.s_rlast[gnt_idx[i]],
                            bus.s_rresp[int'(gnt_idx[i])*2 +: 2],
                            bus.s_rid[int'(gnt_idx[i])*IdWidth +: IdWidth],
                            bus.s_rdata[int'(gnt_idx[i])*AxiBusWidth +: AxiBusWidth]};
            if (push[i]) bus.s_rready[gnt_idx[i]] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            err_drop_q <= '0;
            for (int i = 0; i < NumMasters; i++) begin
                state_q[i] <= ARB_IDLE;
                lock_q[i]  <= '0;
                ptr_q[i]   <= '0;
                wr_q[i]    <= '0;
                rd_q[i]    <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            err_drop_q <= bus.s_rvalid & bad_tgt & {NumSlaves{run_q}};
            for (int i = 0; i < NumMasters; i++) begin
                if (push[i]) begin
                    wr_q[i] <= wr_q[i] + PtrOne;
                    if (push_beat[i][BeatWidth-1]) begin
                        state_q[i] <= ARB_IDLE;
                        ptr_q[i]   <= wrap_add(gnt_idx[i], 1);
                    end else begin
                        state_q[i] <= ARB_LOCKED;
                        lock_q[i]  <= gnt_idx[i];
                    end
                end
                if (pop[i]) rd_q[i] <= rd_q[i] + PtrOne;
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < NumMasters; i++) begin
            if (push[i]) mem_q[i][wr_q[i][PtrWidth-1:0]] <= push_beat[i];
        end
    end

    assign err_drop_o = err_drop_q;
endmodule
